// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared FSM state type and stat counter width for the FIFO write arbiter.
package fifo_write_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
  localparam int STATW = 16;
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester handshake and FIFO write port bundle.
interface fifo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DATAW = 14
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DATAW-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DATAW+IDW-1:0]  wr_port;
  logic                  wr_req;
  logic                  q_full;
  modport master (output req_valid, req_data, req_last, q_full, input req_ready, wr_port, wr_req);
  modport slave  (input req_valid, req_data, req_last, q_full, output req_ready, wr_port, wr_req);
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder starting at index start and wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(start) + i) % N]) begin
        found = 1'b1;
        idx   = W'((int'(start) + i) % N);
      end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, packet-locking arbiter merging NREQ requesters into one FIFO.
// Define FIFO_ARB_STATS_EN to build the per-requester saturating completed-packet counters.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DATAW = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fifo_write_arbiter_if.slave   bus,
  output logic [IDW-1:0]        grant_id,
  output logic                  locked,
  output logic [NREQ*STATW-1:0] stat_pkts
);
  arb_state_t     state;
  logic [IDW-1:0] last_winner, held, pick, start;
  logic           found, xfer, last;
  assign start = (last_winner == IDW'(NREQ - 1)) ? '0 : last_winner + 1'b1;
  rr_pick #(.N(NREQ), .W(IDW)) u_pick (
    .req   (bus.req_valid),
    .start (start),
    .found (found),
    .idx   (pick)
  );
  assign grant_id      = (state == ARB_LOCK) ? held : found ? pick : last_winner;
  assign locked        = (state == ARB_LOCK);
  assign last          = bus.req_last[grant_id];
  // Gated by reset_n so the bus is quiet while reset is held.
  assign bus.wr_req    = reset_n && !bus.q_full && bus.req_valid[grant_id];
  assign bus.req_ready = (reset_n && !bus.q_full) ? NREQ'(1) << grant_id : '0;
  assign bus.wr_port   = {grant_id, bus.req_data[grant_id*DATAW +: DATAW]};
  assign xfer          = bus.wr_req;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= ARB_IDLE;
      last_winner <= IDW'(NREQ - 1);
      held        <= '0;
    end else if (xfer) begin
      if (state == ARB_IDLE) begin
        if (last) last_winner <= grant_id;
        else begin
          state <= ARB_LOCK;
          held  <= grant_id;
        end
      end else if (last) begin
        state       <= ARB_IDLE;
        last_winner <= held;
      end
    end
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
`ifdef FIFO_ARB_STATS_EN
    logic [STATW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (xfer && last && grant_id == IDW'(i) && cnt != '1) cnt <= cnt + 1'b1;
    assign stat_pkts[i*STATW +: STATW] = cnt;
`else
    assign stat_pkts[i*STATW +: STATW] = '0;
`endif
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of arbitration order, packet locking, stalls, reset and stats.
module tb_fifo_write_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  grant_id;
  logic        locked;
  logic [63:0] stat_pkts;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  fifo_write_arbiter_if #(.NREQ(4), .IDW(2), .DATAW(14)) bus ();

  fifo_write_arbiter #(.NREQ(4), .IDW(2), .DATAW(14)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .grant_id  (grant_id),
    .locked    (locked),
    .stat_pkts (stat_pkts)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] dw(int r, int k);
    return 14'(r * 1024 + k);
  endfunction

  function automatic logic [55:0] pack(int k);
    return {dw(3, k), dw(2, k), dw(1, k), dw(0, k)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last = 4'b1111;
    bus.req_data = pack(0);
    bus.q_full = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.wr_req !== 1'b0) $display("FAIL reset_wr_req got %b want 0", bus.wr_req); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else pass_cnt++;
    total_cnt++; if (stat_pkts !== 64'h0) $display("FAIL reset_stats got %h want 0", stat_pkts); else pass_cnt++;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    bus.req_valid = 4'b1111;
    bus.req_last = 4'b1111;
    bus.req_data = pack(0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++; if (grant_id !== 2'(k % 4)) $display("FAIL rr_grant[%0d] got %0d want %0d", k, grant_id, k % 4); else pass_cnt++;
      total_cnt++; if (bus.wr_port !== {2'(k % 4), dw(k % 4, 0)}) $display("FAIL rr_wr_port[%0d] got %h want %h", k, bus.wr_port, {2'(k % 4), dw(k % 4, 0)}); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, 4'(1 << (k % 4))); else pass_cnt++;
      total_cnt++; if (bus.wr_req !== 1'b1) $display("FAIL rr_wr_req[%0d] got %b want 1", k, bus.wr_req); else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_lock();
    bus.req_valid = 4'b0010;
    bus.req_last = 4'b1111;
    bus.req_data = pack(0);
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd1) $display("FAIL lock_pre_grant got %0d want 1", grant_id); else pass_cnt++;
    next_cycle();
    bus.req_valid = 4'b0110;
    bus.req_last = 4'b1011;
    for (int k = 1; k <= 3; k++) begin
      bus.req_data = pack(k);
      if (k == 3) bus.req_last = 4'b1111;
      @(negedge clk);
      total_cnt++; if (grant_id !== 2'd2) $display("FAIL lock_grant[%0d] got %0d want 2", k, grant_id); else pass_cnt++;
      total_cnt++; if (locked !== (k > 1)) $display("FAIL lock_locked[%0d] got %b want %b", k, locked, k > 1); else pass_cnt++;
      total_cnt++; if (bus.wr_port !== {2'd2, dw(2, k)}) $display("FAIL lock_wr_port[%0d] got %h want %h", k, bus.wr_port, {2'd2, dw(2, k)}); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 4'b0100) $display("FAIL lock_ready[%0d] got %b want 0100", k, bus.req_ready); else pass_cnt++;
      next_cycle();
    end
    bus.req_valid = 4'b0010;
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd1) $display("FAIL lock_after_grant got %0d want 1", grant_id); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL lock_after_locked got %b want 0", locked); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_lock_stall();
    bus.req_valid = 4'b1000;
    bus.req_last = 4'b0111;
    bus.req_data = pack(4);
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd3) $display("FAIL stall_first_grant got %0d want 3", grant_id); else pass_cnt++;
    total_cnt++; if (bus.wr_req !== 1'b1) $display("FAIL stall_first_wr_req got %b want 1", bus.wr_req); else pass_cnt++;
    next_cycle();
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++; if (bus.wr_req !== 1'b0) $display("FAIL stall_wr_req[%0d] got %b want 0", k, bus.wr_req); else pass_cnt++;
      total_cnt++; if (grant_id !== 2'd3) $display("FAIL stall_grant[%0d] got %0d want 3", k, grant_id); else pass_cnt++;
      total_cnt++; if (locked !== 1'b1) $display("FAIL stall_locked[%0d] got %b want 1", k, locked); else pass_cnt++;
      next_cycle();
    end
    bus.req_valid = 4'b1011;
    bus.req_last = 4'b1111;
    bus.req_data = pack(5);
    @(negedge clk);
    total_cnt++; if (bus.wr_req !== 1'b1) $display("FAIL stall_resume_wr_req got %b want 1", bus.wr_req); else pass_cnt++;
    total_cnt++; if (bus.wr_port !== {2'd3, dw(3, 5)}) $display("FAIL stall_resume_wr_port got %h want %h", bus.wr_port, {2'd3, dw(3, 5)}); else pass_cnt++;
    next_cycle();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd0) $display("FAIL stall_release_grant got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL stall_release_locked got %b want 0", locked); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_full();
    logic [63:0] stat_exp;
`ifdef FIFO_ARB_STATS_EN
    stat_exp = {16'd2, 16'd2, 16'd3, 16'd3};
`else
    stat_exp = 64'h0;
`endif
    bus.q_full = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last = 4'b1111;
    bus.req_data = pack(6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL full_ready[%0d] got %b want 0000", k, bus.req_ready); else pass_cnt++;
      total_cnt++; if (bus.wr_req !== 1'b0) $display("FAIL full_wr_req[%0d] got %b want 0", k, bus.wr_req); else pass_cnt++;
      total_cnt++; if (grant_id !== 2'd1) $display("FAIL full_grant[%0d] got %0d want 1", k, grant_id); else pass_cnt++;
      next_cycle();
    end
    total_cnt++; if (stat_pkts !== stat_exp) $display("FAIL full_stats got %h want %h", stat_pkts, stat_exp); else pass_cnt++;
    bus.q_full = 1'b0;
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd1) $display("FAIL full_release_grant got %0d want 1", grant_id); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0010) $display("FAIL full_release_ready got %b want 0010", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.wr_port !== {2'd1, dw(1, 6)}) $display("FAIL full_release_wr_port got %h want %h", bus.wr_port, {2'd1, dw(1, 6)}); else pass_cnt++;
    next_cycle();
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_lock();
    bus.req_valid = 4'b0100;
    bus.req_last = 4'b0000;
    bus.req_data = pack(7);
    next_cycle();
    @(negedge clk);
    total_cnt++; if (locked !== 1'b1) $display("FAIL midrst_locked_before got %b want 1", locked); else pass_cnt++;
    #1;
    reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last = 4'b1111;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL midrst_ready got %b want 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.wr_req !== 1'b0) $display("FAIL midrst_wr_req got %b want 0", bus.wr_req); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL midrst_locked got %b want 0", locked); else pass_cnt++;
    total_cnt++; if (stat_pkts !== 64'h0) $display("FAIL midrst_stats got %h want 0", stat_pkts); else pass_cnt++;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd0) $display("FAIL midrst_first_grant got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0001) $display("FAIL midrst_first_ready got %b want 0001", bus.req_ready); else pass_cnt++;
    next_cycle();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total_cnt++; if (grant_id !== 2'd0) $display("FAIL idle_grant got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (bus.wr_req !== 1'b0) $display("FAIL idle_wr_req got %b want 0", bus.wr_req); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_stats();
    bus.req_valid = 4'b0001;
    bus.req_last = 4'b1111;
`ifdef FIFO_ARB_STATS_EN
    repeat (70000) @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total_cnt++; if (stat_pkts[15:0] !== 16'hFFFF) $display("FAIL stats_sat got %h want ffff", stat_pkts[15:0]); else pass_cnt++;
    total_cnt++; if (stat_pkts[63:16] !== 48'h0) $display("FAIL stats_others got %h want 0", stat_pkts[63:16]); else pass_cnt++;
`else
    repeat (20) @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total_cnt++; if (stat_pkts !== 64'h0) $display("FAIL stats_tied got %h want 0", stat_pkts); else pass_cnt++;
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.q_full = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_stall();
    test_full();
    test_reset_mid_lock();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
